// File: rtl/ahb_pipe_mux_slave.sv
// Slave-side AHB channel multiplexer: one-hot address-phase payload select,
// data-phase owner tracking for write-data steering, and select-fault counting.
module ahb_pipe_mux_slave #(
   parameter int CHANNEL_NUM = 4,
   parameter int PAYLOAD     = 78,
   parameter int DATA_W      = 32,
   parameter int REG_OUT     = 0,
   parameter int ERR_CNT_W   = 8
) (
   input  logic                                hclk,
   input  logic                                hreset,
   input  logic [CHANNEL_NUM-1:0][PAYLOAD-1:0] payload_in,
   input  logic [CHANNEL_NUM-1:0]              sel,
   input  logic                                hready,
   input  logic [CHANNEL_NUM-1:0][DATA_W-1:0]  wdata_in,
   output logic [PAYLOAD-1:0]                  payload_out,
   output logic [DATA_W-1:0]                   wdata_out,
   output logic [CHANNEL_NUM-1:0]              dsel,
   output logic                                data_active,
   output logic                                sel_err,
   output logic [ERR_CNT_W-1:0]                err_cnt
);

   logic [CHANNEL_NUM-1:0] sel_minus_one;
   logic                   sel_legal;
   logic [PAYLOAD-1:0]     mux_payload;

   // Clearing the lowest set bit leaves zero only for idle or one-hot values.
   assign sel_minus_one = sel - CHANNEL_NUM'(1);
   assign sel_legal     = ((sel & sel_minus_one) == '0);

   always_comb begin
      mux_payload = '0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         if (sel_legal && sel[i]) begin
            mux_payload = payload_in[i];
         end
      end
   end

   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic [PAYLOAD-1:0] payload_q;

         always_ff @(posedge hclk) begin
            if (hreset) begin
               payload_q <= '0;
            end else if (hready) begin
               payload_q <= mux_payload;
            end
         end

         assign payload_out = payload_q;
      end else begin : g_comb_out
         assign payload_out = mux_payload;
      end
   endgenerate

   // The data-phase owner only advances when the slave accepts the address phase.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         dsel <= '0;
      end else if (hready) begin
         dsel <= sel_legal ? sel : '0;
      end
   end

   assign data_active = |dsel;

   always_comb begin
      wdata_out = '0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         if (dsel[i]) begin
            wdata_out = wdata_in[i];
         end
      end
   end

   // Faults are only recognised on accepted address phases; the counter saturates.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         sel_err <= 1'b0;
         err_cnt <= '0;
      end else if (hready && !sel_legal) begin
         sel_err <= 1'b1;
         if (err_cnt != {ERR_CNT_W{1'b1}}) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
      end else begin
         sel_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ahb_pipe_mux_slave.sv
// Scoreboard bench: a combinational-output instance (8-bit fault counter) and a
// registered-output instance (2-bit fault counter) share the same stimulus.
module tb_ahb_pipe_mux_slave;

   localparam int CH = 4;
   localparam int PW = 78;
   localparam int DW = 32;

   logic                 hclk = 1'b0;
   logic                 hreset;
   logic [CH-1:0][PW-1:0] payload_in;
   logic [CH-1:0]        sel;
   logic                 hready;
   logic [CH-1:0][DW-1:0] wdata_in;

   logic [PW-1:0] payload_out,  payload_out_r;
   logic [DW-1:0] wdata_out,    wdata_out_r;
   logic [CH-1:0] dsel,         dsel_r;
   logic          data_active,  data_active_r;
   logic          sel_err,      sel_err_r;
   logic [7:0]    err_cnt;
   logic [1:0]    err_cnt_r;

   typedef struct {
      logic [PW-1:0] payload;
      logic [PW-1:0] preg;
      logic [DW-1:0] wdata;
      logic [CH-1:0] dsel;
      logic          serr;
      logic [7:0]    cnt;
      logic [1:0]    cnt2;
   } exp_t;

   exp_t sb[$];

   int compared   = 0;
   int mismatched = 0;

   logic [CH-1:0] m_dsel;
   logic          m_err;
   logic [7:0]    m_cnt;
   logic [1:0]    m_cnt2;
   logic [PW-1:0] m_preg;
   logic          model_valid = 1'b0;

   always #5 hclk = ~hclk;

   ahb_pipe_mux_slave #(
      .CHANNEL_NUM(CH), .PAYLOAD(PW), .DATA_W(DW), .REG_OUT(0), .ERR_CNT_W(8)
   ) dut (
      .hclk(hclk), .hreset(hreset), .payload_in(payload_in), .sel(sel),
      .hready(hready), .wdata_in(wdata_in), .payload_out(payload_out),
      .wdata_out(wdata_out), .dsel(dsel), .data_active(data_active),
      .sel_err(sel_err), .err_cnt(err_cnt)
   );

   ahb_pipe_mux_slave #(
      .CHANNEL_NUM(CH), .PAYLOAD(PW), .DATA_W(DW), .REG_OUT(1), .ERR_CNT_W(2)
   ) dut_reg (
      .hclk(hclk), .hreset(hreset), .payload_in(payload_in), .sel(sel),
      .hready(hready), .wdata_in(wdata_in), .payload_out(payload_out_r),
      .wdata_out(wdata_out_r), .dsel(dsel_r), .data_active(data_active_r),
      .sel_err(sel_err_r), .err_cnt(err_cnt_r)
   );

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
      end
   endtask

   function automatic logic [PW-1:0] refPayload(input logic [CH-1:0] s);
      logic [PW-1:0] r = '0;
      if ($countones(s) == 1) begin
         for (int i = 0; i < CH; i++) if (s == (CH'(1) << i)) r = payload_in[i];
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] refWdata(input logic [CH-1:0] d);
      logic [DW-1:0] r = '0;
      for (int i = 0; i < CH; i++) if (d == (CH'(1) << i)) r = wdata_in[i];
      return r;
   endfunction

   // Drive one cycle, push what the DUTs must show before the coming edge,
   // then advance the reference state past that edge.
   task automatic applyStimulus(input logic [CH-1:0] s, input logic hr, input logic rst);
      logic [95:0] wide;
      exp_t        e;
      bit          legal;
      @(posedge hclk);
      #1;
      sel    = s;
      hready = hr;
      hreset = rst;
      for (int c = 0; c < CH; c++) begin
         wide          = {$urandom, $urandom, $urandom};
         payload_in[c] = wide[PW-1:0];
         wdata_in[c]   = $urandom;
      end
      if (model_valid) begin
         e.payload = refPayload(s);
         e.preg    = m_preg;
         e.wdata   = refWdata(m_dsel);
         e.dsel    = m_dsel;
         e.serr    = m_err;
         e.cnt     = m_cnt;
         e.cnt2    = m_cnt2;
         sb.push_back(e);
      end
      legal = ($countones(s) <= 1);
      if (rst) begin
         m_dsel = '0; m_err = 1'b0; m_cnt = '0; m_cnt2 = '0; m_preg = '0;
         model_valid = 1'b1;
      end else if (hr) begin
         m_preg = refPayload(s);
         m_dsel = legal ? s : '0;
         m_err  = !legal;
         if (!legal && m_cnt  != 8'hFF) m_cnt  = m_cnt + 8'd1;
         if (!legal && m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
      end else begin
         m_err = 1'b0;
      end
   endtask

   always @(negedge hclk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("payload_out",     128'(payload_out),   128'(e.payload));
         checkOutput("wdata_out",       128'(wdata_out),     128'(e.wdata));
         checkOutput("dsel",            128'(dsel),          128'(e.dsel));
         checkOutput("data_active",     128'(data_active),   128'(|e.dsel));
         checkOutput("sel_err",         128'(sel_err),       128'(e.serr));
         checkOutput("err_cnt",         128'(err_cnt),       128'(e.cnt));
         checkOutput("payload_out_reg", 128'(payload_out_r), 128'(e.preg));
         checkOutput("wdata_out_reg",   128'(wdata_out_r),   128'(e.wdata));
         checkOutput("dsel_reg",        128'(dsel_r),        128'(e.dsel));
         checkOutput("sel_err_reg",     128'(sel_err_r),     128'(e.serr));
         checkOutput("err_cnt_sat",     128'(err_cnt_r),     128'(e.cnt2));
      end
   end

   initial begin
      hreset = 1'b1; hready = 1'b1; sel = '0; payload_in = '0; wdata_in = '0;
      m_dsel = '0; m_err = 1'b0; m_cnt = '0; m_cnt2 = '0; m_preg = '0;

      // Reset and idle, including a grant visible combinationally during reset
      applyStimulus(4'b0000, 1'b1, 1'b1);
      applyStimulus(4'b0000, 1'b1, 1'b1);
      applyStimulus(4'b0010, 1'b1, 1'b1);
      applyStimulus(4'b0000, 1'b1, 1'b0);

      // Pipelined steering ch1 -> ch3
      applyStimulus(4'b0010, 1'b1, 1'b0);
      applyStimulus(4'b1000, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);

      // Wait states hold the ch2 data phase
      applyStimulus(4'b0100, 1'b1, 1'b0);
      applyStimulus(4'b0001, 1'b0, 1'b0);
      applyStimulus(4'b0001, 1'b0, 1'b0);
      applyStimulus(4'b0001, 1'b0, 1'b0);
      applyStimulus(4'b0001, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);

      // Illegal select, accepted and then during a wait state
      applyStimulus(4'b0110, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      applyStimulus(4'b0110, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);

      // Saturation of the 2-bit counter from a clean reset
      applyStimulus(4'b0000, 1'b1, 1'b1);
      applyStimulus(4'b0110, 1'b1, 1'b0);
      applyStimulus(4'b1001, 1'b1, 1'b0);
      applyStimulus(4'b0011, 1'b1, 1'b0);
      applyStimulus(4'b1100, 1'b1, 1'b0);
      applyStimulus(4'b1111, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);

      // Registered output hold, then reset mid-transfer during a wait state
      applyStimulus(4'b0010, 1'b1, 1'b0);
      applyStimulus(4'b0100, 1'b0, 1'b0);
      applyStimulus(4'b1000, 1'b1, 1'b0);
      applyStimulus(4'b0001, 1'b0, 1'b1);
      applyStimulus(4'b0000, 1'b1, 1'b0);

      for (int n = 0; n < 60; n++) begin
         applyStimulus(CH'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 1'b0);
      end
      applyStimulus(4'b0000, 1'b1, 1'b0);

      @(posedge hclk);
      #1;
      checkOutput("scoreboard_drained", 128'(sb.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ahb_pipe_mux_slave.md
# ahb_pipe_mux_slave

Parametrised slave-side AHB channel multiplexer with pipeline tracking. It selects one of CHANNEL_NUM master address-phase payloads by one-hot select, with an optional output register. It also holds the granted channel across the AHB data phase, so the matching write-data payload is steered to the slave one cycle after the address phase. It sits between the generated arbiter and each slave port, and adds select-fault detection and a saturating fault counter.

## Interface
Parameters:
- CHANNEL_NUM, 4: number of master channels (1..16).
- PAYLOAD, 78: address/control payload width per channel.
- DATA_W, 32: write-data payload width per channel.
- REG_OUT, 0: 0 = address payload combinational; 1 = address payload registered (one-cycle latency).
- ERR_CNT_W, 8: width of the select-fault counter.

Ports:
- hclk  in  1  single clock, rising edge.
- hreset  in  1  synchronous, active-high reset.
- payload_in  in  [CHANNEL_NUM][PAYLOAD]  per-channel address-phase payload.
- sel  in  CHANNEL_NUM  one-hot grant from arbiter; all-zero = idle.
- hready  in  1  slave-side HREADY; advances address and data phases.
- wdata_in  in  [CHANNEL_NUM][DATA_W]  per-channel write data, valid in data phase.
- payload_out  out  PAYLOAD  selected address payload.
- wdata_out  out  DATA_W  write data of channel owning the current data phase.
- dsel  out  CHANNEL_NUM  registered data-phase owner (one-hot or zero).
- data_active  out  1  |dsel.
- sel_err  out  1  one-cycle pulse: illegal sel sampled.
- err_cnt  out  ERR_CNT_W  saturating count of illegal sel samples.

## Operation
- Legal sel: all-zero, or exactly one bit set. Any other value is illegal.
- Address mux: payload_out = payload_in[i] when sel == (1<<i). It is all-zero for idle or illegal sel. No priority resolution is applied to multi-hot values.
- REG_OUT=1: the mux result is captured into the output register on every edge where hready=1. The register holds while hready=0.
- Data-phase owner: on each edge with hready=1, dsel <= sel if sel is legal, else dsel <= 0. With hready=0, dsel holds, so the data phase is extended by wait states.
- wdata_out = wdata_in[i] where dsel == (1<<i); all-zero when dsel == 0. This output is combinational from dsel and wdata_in.
- Fault detection: on an edge with hready=1 and illegal sel:
  - sel_err is 1 for the following cycle.
  - err_cnt increments, saturating at 2^ERR_CNT_W-1.
- An illegal sel while hready=0 is not counted.
- err_cnt is cleared only by reset.
- CHANNEL_NUM=1: sel[0] is the only legal non-idle value, and sel_err never asserts.

## Timing
- Reset (hreset=1 at an edge): dsel=0, data_active=0, sel_err=0, err_cnt=0, and the REG_OUT=1 output register is 0.
  - wdata_out=0 follows from dsel=0.
  - With REG_OUT=0, payload_out stays combinational during reset.
- Reset mid-transfer: the data phase is abandoned and dsel=0 from the next cycle, regardless of hready.
- Address latency: 0 cycles (REG_OUT=0) or 1 cycle (REG_OUT=1).
- Data latency: the channel granted in address cycle N owns wdata_out from cycle N+1 until the first edge after N+1 with hready=1.
- Back-to-back grants to different channels with hready=1 switch the owner every cycle, with no bubble.
- sel_err is registered and asserts one cycle after the offending sample. Consecutive illegal samples give a continuous high level and count once per cycle.
- Saturation: at max value err_cnt holds, while sel_err still pulses.

## Test plan
- Reset/idle: hold hreset=1 for 2 cycles, then sel=0 -> payload_out=0, wdata_out=0, dsel=0, err_cnt=0.
- Pipelined steering (CHANNEL_NUM=4, REG_OUT=0): sel=4'b0010 with hready=1, then sel=4'b1000 -> payload_out tracks ch1 then ch3 same-cycle. dsel = 0010 then 1000 one cycle later, and wdata_out = wdata_in[1] then wdata_in[3].
- Wait states: grant ch2, then hready=0 for 3 cycles while sel changes to ch0 -> dsel stays 0100 and wdata_out = wdata_in[2] throughout. dsel becomes 0001 only after hready returns high.
- Illegal select: sel=4'b0110 with hready=1 -> payload_out=0, next-cycle dsel=0, sel_err=1, err_cnt=1. The same sel with hready=0 leaves err_cnt unchanged.
- Saturation (ERR_CNT_W=2): 5 consecutive illegal samples -> err_cnt = 1,2,3,3,3 and sel_err high for 5 cycles.
- REG_OUT=1: sel=ch1 at cycle N -> payload_out = payload_in[1] from cycle N+1. With hready=0 at N, payload_out keeps its previous value. Reset mid-stream -> payload_out=0 next cycle.
